// File: rtl/sc_level_sequencer.sv
// ---------------------------------------------------------------------------
// sc_level_sequencer
// Frogger game-level sequencer. Turns frog-home events into one-cycle
// active-low count pulses for the progress counter, clears that counter at
// game start and on each level change, advances the level when the count
// reaches the goal, tracks lives and declares win or loss.
//
// Optional feature macro: SC_LEVELSEQUENCER_LIVES_EN
//   defined   : lives counter, FrogDead edge detection and LOSE are active.
//   undefined : FrogDead_In ignored, Lives_OutBus and Lose_Out stay 0,
//               the game can only end in WIN.
//
// Ports
//   SC_LEVELSEQUENCER_CLOCK_50              in   system clock
//   SC_LEVELSEQUENCER_RESET_InLow           in   async reset, active-low
//   SC_LEVELSEQUENCER_StartButton_InLow     in   start button (synchronized)
//   SC_LEVELSEQUENCER_FrogHome_In           in   frog home, rising edge counts
//   SC_LEVELSEQUENCER_FrogDead_In           in   frog killed, rising edge counts
//   SC_LEVELSEQUENCER_Progress_InBus        in   count from progress counter
//   SC_LEVELSEQUENCER_CountSignal_OutLow    out  one-cycle count pulse (low)
//   SC_LEVELSEQUENCER_StartCountSignal_Out  out  synchronous counter clear
//   SC_LEVELSEQUENCER_GameActive_Out        out  counter enable
//   SC_LEVELSEQUENCER_Level_OutBus          out  current level, 0 when idle
//   SC_LEVELSEQUENCER_Lives_OutBus          out  remaining lives
//   SC_LEVELSEQUENCER_LevelUp_Out           out  pulse on each level advance
//   SC_LEVELSEQUENCER_Win_Out               out  high while in WIN
//   SC_LEVELSEQUENCER_Lose_Out              out  high while in LOSE
// ---------------------------------------------------------------------------
module sc_level_sequencer #(
  parameter int unsigned LEVELSEQUENCER_DATAWIDTH  = 5,
  parameter int unsigned LEVELSEQUENCER_LEVELWIDTH = 3,
  parameter int unsigned LEVELSEQUENCER_GOAL       = 5,
  parameter int unsigned LEVELSEQUENCER_MAXLEVEL   = 4,
  parameter int unsigned LEVELSEQUENCER_LIVES      = 3
) (
  input  logic                                 SC_LEVELSEQUENCER_CLOCK_50,
  input  logic                                 SC_LEVELSEQUENCER_RESET_InLow,
  input  logic                                 SC_LEVELSEQUENCER_StartButton_InLow,
  input  logic                                 SC_LEVELSEQUENCER_FrogHome_In,
  input  logic                                 SC_LEVELSEQUENCER_FrogDead_In,
  input  logic [LEVELSEQUENCER_DATAWIDTH-1:0]  SC_LEVELSEQUENCER_Progress_InBus,
  output logic                                 SC_LEVELSEQUENCER_CountSignal_OutLow,
  output logic                                 SC_LEVELSEQUENCER_StartCountSignal_Out,
  output logic                                 SC_LEVELSEQUENCER_GameActive_Out,
  output logic [LEVELSEQUENCER_LEVELWIDTH-1:0] SC_LEVELSEQUENCER_Level_OutBus,
  output logic [1:0]                           SC_LEVELSEQUENCER_Lives_OutBus,
  output logic                                 SC_LEVELSEQUENCER_LevelUp_Out,
  output logic                                 SC_LEVELSEQUENCER_Win_Out,
  output logic                                 SC_LEVELSEQUENCER_Lose_Out
);

  localparam int unsigned DW = LEVELSEQUENCER_DATAWIDTH;
  localparam int unsigned LW = LEVELSEQUENCER_LEVELWIDTH;

`ifdef SC_LEVELSEQUENCER_LIVES_EN
  localparam bit LIVES_EN_C = 1'b1;
`else
  localparam bit LIVES_EN_C = 1'b0;
`endif

  localparam logic [DW-1:0] GOAL_C      = DW'(LEVELSEQUENCER_GOAL);
  localparam logic [LW-1:0] MAXLEVEL_C  = LW'(LEVELSEQUENCER_MAXLEVEL);
  localparam logic [LW-1:0] LEVEL_ONE_C = LW'(1);
  // Lives load value; with the lives feature off the counter stays at zero.
  localparam logic [1:0]    LIVES_LOAD_C = LIVES_EN_C ? 2'(LEVELSEQUENCER_LIVES) : 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_LEVELUP = 3'd3,
    ST_WIN     = 3'd4,
    ST_LOSE    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      lives_q, lives_d;
  logic            count_n_q, count_n_d;
  logic            start_count_q, start_count_d;
  logic            active_q, active_d;
  logic            level_up_q, level_up_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;

  logic            start_prev_q;
  logic            home_prev_q;

  logic            start_ev_c;
  logic            home_ev_c;
  logic            dead_ev_c;
  logic            goal_c;

  // Event detection: start on falling edge, home/death on rising edge.
  assign start_ev_c = start_prev_q & ~SC_LEVELSEQUENCER_StartButton_InLow;
  assign home_ev_c  = SC_LEVELSEQUENCER_FrogHome_In & ~home_prev_q;
  assign goal_c     = (SC_LEVELSEQUENCER_Progress_InBus >= GOAL_C);

`ifdef SC_LEVELSEQUENCER_LIVES_EN
  logic dead_prev_q;

  assign dead_ev_c = SC_LEVELSEQUENCER_FrogDead_In & ~dead_prev_q;

  // Death previous-value register.
  always_ff @(posedge SC_LEVELSEQUENCER_CLOCK_50 or negedge SC_LEVELSEQUENCER_RESET_InLow) begin
    if (!SC_LEVELSEQUENCER_RESET_InLow) begin
      dead_prev_q <= 1'b0;
    end else begin
      dead_prev_q <= SC_LEVELSEQUENCER_FrogDead_In;
    end
  end
`else
  logic unused_frog_dead_c;

  assign unused_frog_dead_c = SC_LEVELSEQUENCER_FrogDead_In;
  assign dead_ev_c          = 1'b0;
`endif

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    count_n_d     = 1'b1;
    start_count_d = 1'b0;
    active_d      = active_q;
    level_up_d    = 1'b0;
    win_d         = win_q;
    lose_d        = lose_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ev_c) begin
          state_d       = ST_CLEAR;
          level_d       = LEVEL_ONE_C;
          lives_d       = LIVES_LOAD_C;
          start_count_d = 1'b1;
          active_d      = 1'b1;
        end
      end

      ST_CLEAR: begin
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        // A home event always pulses, whatever else happens this cycle.
        count_n_d = ~home_ev_c;
        if (dead_ev_c && (lives_q != 2'd0)) begin
          lives_d = lives_q - 2'd1;
        end
        // Losing the last life outranks reaching the goal.
        if (dead_ev_c && (lives_q == 2'd1)) begin
          state_d  = ST_LOSE;
          active_d = 1'b0;
          lose_d   = 1'b1;
        end else if (goal_c) begin
          if (level_q >= MAXLEVEL_C) begin
            state_d  = ST_WIN;
            active_d = 1'b0;
            win_d    = 1'b1;
          end else begin
            state_d       = ST_LEVELUP;
            level_d       = level_q + LW'(1);
            level_up_d    = 1'b1;
            start_count_d = 1'b1;
          end
        end
      end

      ST_LEVELUP: begin
        state_d = ST_PLAY;
      end

      ST_WIN, ST_LOSE: begin
        if (start_ev_c) begin
          state_d       = ST_CLEAR;
          level_d       = LEVEL_ONE_C;
          lives_d       = LIVES_LOAD_C;
          start_count_d = 1'b1;
          active_d      = 1'b1;
          win_d         = 1'b0;
          lose_d        = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        level_d  = '0;
        lives_d  = 2'd0;
        active_d = 1'b0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
      end
    endcase
  end

  // State, output and edge-detect registers.
  always_ff @(posedge SC_LEVELSEQUENCER_CLOCK_50 or negedge SC_LEVELSEQUENCER_RESET_InLow) begin
    if (!SC_LEVELSEQUENCER_RESET_InLow) begin
      state_q       <= ST_IDLE;
      level_q       <= '0;
      lives_q       <= 2'd0;
      count_n_q     <= 1'b1;
      start_count_q <= 1'b0;
      active_q      <= 1'b0;
      level_up_q    <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      start_prev_q  <= 1'b1;
      home_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      count_n_q     <= count_n_d;
      start_count_q <= start_count_d;
      active_q      <= active_d;
      level_up_q    <= level_up_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      start_prev_q  <= SC_LEVELSEQUENCER_StartButton_InLow;
      home_prev_q   <= SC_LEVELSEQUENCER_FrogHome_In;
    end
  end

  assign SC_LEVELSEQUENCER_CountSignal_OutLow   = count_n_q;
  assign SC_LEVELSEQUENCER_StartCountSignal_Out = start_count_q;
  assign SC_LEVELSEQUENCER_GameActive_Out       = active_q;
  assign SC_LEVELSEQUENCER_Level_OutBus         = level_q;
  assign SC_LEVELSEQUENCER_Lives_OutBus         = lives_q;
  assign SC_LEVELSEQUENCER_LevelUp_Out          = level_up_q;
  assign SC_LEVELSEQUENCER_Win_Out              = win_q;
  assign SC_LEVELSEQUENCER_Lose_Out             = lose_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sc_level_sequencer
// Self-checking bench for sc_level_sequencer: directed game scenarios plus a
// randomized phase, all compared against a behavioural game model that tracks
// the expected display/counter outputs directly.
// ---------------------------------------------------------------------------
module tb_sc_level_sequencer;

  localparam int GOAL     = 5;
  localparam int MAXLEVEL = 4;
  localparam int LIVES    = 3;
`ifdef SC_LEVELSEQUENCER_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n;
  logic       home;
  logic       dead;
  logic [4:0] prog;

  logic       cnt_n;
  logic       start_cnt;
  logic       active;
  logic [2:0] level;
  logic [1:0] lives;
  logic       level_up;
  logic       win;
  logic       lose;

  sc_level_sequencer dut (
    .SC_LEVELSEQUENCER_CLOCK_50             (clk),
    .SC_LEVELSEQUENCER_RESET_InLow          (rst_n),
    .SC_LEVELSEQUENCER_StartButton_InLow    (start_n),
    .SC_LEVELSEQUENCER_FrogHome_In          (home),
    .SC_LEVELSEQUENCER_FrogDead_In          (dead),
    .SC_LEVELSEQUENCER_Progress_InBus       (prog),
    .SC_LEVELSEQUENCER_CountSignal_OutLow   (cnt_n),
    .SC_LEVELSEQUENCER_StartCountSignal_Out (start_cnt),
    .SC_LEVELSEQUENCER_GameActive_Out       (active),
    .SC_LEVELSEQUENCER_Level_OutBus         (level),
    .SC_LEVELSEQUENCER_Lives_OutBus         (lives),
    .SC_LEVELSEQUENCER_LevelUp_Out          (level_up),
    .SC_LEVELSEQUENCER_Win_Out              (win),
    .SC_LEVELSEQUENCER_Lose_Out             (lose)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs of the game model.
  int e_level;
  int e_lives;
  bit e_cnt_n, e_sc, e_act, e_up, e_win, e_lose;
  // Previous input values as seen by the game.
  bit p_start, p_home, p_dead;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_level = 0; e_lives = 0;
    e_cnt_n = 1'b1; e_sc = 1'b0; e_act = 1'b0; e_up = 1'b0; e_win = 1'b0; e_lose = 1'b0;
    p_start = 1'b1; p_home = 1'b0; p_dead = 1'b0;
  endtask

  // Advance the game model by one clock using the inputs currently applied.
  task automatic model_clock();
    bit st_ev, home_ev, dead_ev;
    bit is_idle, is_clear, is_up, is_over;
    st_ev   = p_start && !start_n;
    home_ev = home && !p_home;
    dead_ev = LIVES_EN && dead && !p_dead;
    // The game phase is read off the visible outputs.
    is_idle  = (e_level == 0);
    is_up    = e_up;
    is_clear = e_sc && !e_up;
    is_over  = e_win || e_lose;
    e_cnt_n = 1'b1;
    e_sc    = 1'b0;
    e_up    = 1'b0;
    if (is_idle || is_over) begin
      if (st_ev) begin
        e_level = 1;
        e_lives = LIVES_EN ? LIVES : 0;
        e_sc = 1'b1; e_act = 1'b1; e_win = 1'b0; e_lose = 1'b0;
      end
    end else if (is_clear || is_up) begin
      // one-cycle phases return to play
    end else begin
      e_cnt_n = !home_ev;
      if (dead_ev && e_lives == 1) begin
        e_lives = 0; e_act = 1'b0; e_lose = 1'b1;
      end else begin
        if (dead_ev && e_lives > 0) e_lives = e_lives - 1;
        if (int'(prog) >= GOAL) begin
          if (e_level == MAXLEVEL) begin
            e_win = 1'b1; e_act = 1'b0;
          end else begin
            e_level = e_level + 1; e_up = 1'b1; e_sc = 1'b1;
          end
        end
      end
    end
    p_start = start_n; p_home = home; p_dead = dead;
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".cnt_n"},    32'(cnt_n),     32'(e_cnt_n));
    check_eq({ctx, ".startcnt"}, 32'(start_cnt), 32'(e_sc));
    check_eq({ctx, ".active"},   32'(active),    32'(e_act));
    check_eq({ctx, ".level"},    32'(level),     32'(e_level));
    check_eq({ctx, ".lives"},    32'(lives),     32'(e_lives));
    check_eq({ctx, ".levelup"},  32'(level_up),  32'(e_up));
    check_eq({ctx, ".win"},      32'(win),       32'(e_win));
    check_eq({ctx, ".lose"},     32'(lose),      32'(e_lose));
  endtask

  // Apply inputs just after a falling edge, clock once, check at the next falling edge.
  task automatic step(input string ctx, input bit s, input bit h, input bit d, input int p);
    start_n = s; home = h; dead = d; prog = 5'(p);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic press_start(input string ctx);
    step(ctx, 1'b0, 1'b0, 1'b0, 0);
    step(ctx, 1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int lows;
    bit s, h, d;
    int p;

    rst_n = 1'b0; start_n = 1'b1; home = 1'b0; dead = 1'b0; prog = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0, 1'b0, 0);

    // Start: one CLEAR cycle, then PLAY at level 1.
    step("start", 1'b0, 1'b0, 1'b0, 0);
    check_eq("clear_startcnt", 32'(start_cnt), 32'd1);
    check_eq("clear_level", 32'(level), 32'd1);
    step("play", 1'b1, 1'b0, 1'b0, 0);
    check_eq("play_active", 32'(active), 32'd1);
    check_eq("play_startcnt", 32'(start_cnt), 32'd0);

    // Held FrogHome: exactly one pulse.
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step("hold", 1'b1, 1'b1, 1'b0, 0);
      if (cnt_n === 1'b0) lows++;
    end
    check_eq("hold_pulses", 32'(lows), 32'd1);
    step("release", 1'b1, 1'b0, 1'b0, 0);

    // Back-to-back home events.
    step("b2b0", 1'b1, 1'b1, 1'b0, 0);
    step("b2b1", 1'b1, 1'b0, 1'b0, 0);
    step("b2b2", 1'b1, 1'b1, 1'b0, 0);

    // Levels 1..3 advance, level 4 wins.
    for (int l = 1; l < MAXLEVEL; l++) begin
      step("goal", 1'b1, 1'b0, 1'b0, GOAL);
      check_eq("levelup_pulse", 32'(level_up), 32'd1);
      check_eq("levelup_level", 32'(level), 32'(l + 1));
      step("after_up", 1'b1, 1'b0, 1'b0, 0);
    end
    step("win", 1'b1, 1'b0, 1'b0, 31);
    check_eq("win_flag", 32'(win), 32'd1);
    check_eq("win_active", 32'(active), 32'd0);
    step("win_hold", 1'b1, 1'b1, 1'b1, 31);
    press_start("restart");
    check_eq("restart_level", 32'(level), 32'd1);

    // Deaths: lives 3,2,1 then last death coincident with goal loses.
    step("die1", 1'b1, 1'b0, 1'b1, 0);
    step("die1r", 1'b1, 1'b0, 1'b0, 0);
    step("die2", 1'b1, 1'b0, 1'b1, 0);
    step("die2r", 1'b1, 1'b0, 1'b0, 0);
    step("die3", 1'b1, 1'b1, 1'b1, GOAL);
    if (LIVES_EN) begin
      check_eq("lose_flag", 32'(lose), 32'd1);
      check_eq("lose_lives", 32'(lives), 32'd0);
    end else begin
      check_eq("nolives_lose", 32'(lose), 32'd0);
    end
    step("post", 1'b1, 1'b0, 1'b0, 0);
    press_start("restart2");

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 24) != 0);
      h = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 11) == 0) ? int'($urandom_range(5, 31)) : int'($urandom_range(0, 4));
      step("rand", s, h, d, p);
    end

    // Reset during a count pulse.
    press_start("pre_rst");
    step("pre_rst_play", 1'b1, 1'b0, 1'b0, 0);
    step("pre_rst_home", 1'b1, 1'b1, 1'b0, 0);
    check_eq("pulse_before_reset", 32'(cnt_n), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_cnt_n", 32'(cnt_n), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);
    check_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b1, 1'b0, GOAL);
    check_eq("post_rst_idle", 32'(active), 32'd0);
    press_start("post_rst_start");
    check_eq("post_rst_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_level_sequencer.md
# sc_level_sequencer

Game-level sequencer for Frogger. It drives the level progress counter's inputs and reads back its count:
- turns frog-home events into single-cycle active-low count pulses;
- clears the counter at game start and on every level change;
- advances the level when the count reaches the goal;
- tracks lives, and declares win or loss.

It sits between the frog/collision logic and the progress counter, and feeds the level and status displays.

## Interface
Parameters:
- LEVELSEQUENCER_DATAWIDTH, 5, width of the progress count bus.
- LEVELSEQUENCER_LEVELWIDTH, 3, width of the level bus; must hold LEVELSEQUENCER_MAXLEVEL.
- LEVELSEQUENCER_GOAL, 5, frogs home required to finish a level.
- LEVELSEQUENCER_MAXLEVEL, 4, last level; finishing it wins.
- LEVELSEQUENCER_LIVES, 3, lives at game start (2-bit range, 1..3).

Ports:
- SC_LEVELSEQUENCER_CLOCK_50  in  1  system clock, the single clock of this block.
- SC_LEVELSEQUENCER_RESET_InLow  in  1  asynchronous reset, active-low.
- SC_LEVELSEQUENCER_StartButton_InLow  in  1  start button, active-low, already synchronized.
- SC_LEVELSEQUENCER_FrogHome_In  in  1  frog reached home; level or pulse; rising edge counts.
- SC_LEVELSEQUENCER_FrogDead_In  in  1  frog killed; rising edge counts.
- SC_LEVELSEQUENCER_Progress_InBus  in  DATAWIDTH  current count from the progress counter.
- SC_LEVELSEQUENCER_CountSignal_OutLow  out  1  count pulse to the counter, active-low, one cycle.
- SC_LEVELSEQUENCER_StartCountSignal_Out  out  1  synchronous clear to the counter.
- SC_LEVELSEQUENCER_GameActive_Out  out  1  counter enable; counter is held at zero while low.
- SC_LEVELSEQUENCER_Level_OutBus  out  LEVELWIDTH  current level, 1-based; 0 when idle.
- SC_LEVELSEQUENCER_Lives_OutBus  out  2  remaining lives.
- SC_LEVELSEQUENCER_LevelUp_Out  out  1  one-cycle pulse on each level advance.
- SC_LEVELSEQUENCER_Win_Out  out  1  high while in WIN.
- SC_LEVELSEQUENCER_Lose_Out  out  1  high while in LOSE.

## Operation
- All outputs are registered.
- Edge detection: a previous-value register on StartButton, FrogHome and FrogDead.
  - Start event = falling edge of StartButton_InLow.
  - Home and death events = rising edges of their inputs.
- State machine states: IDLE, CLEAR, PLAY, LEVELUP, WIN, LOSE.
- IDLE:
  - Outputs: GameActive=0, Level=0, Lives=0.
  - Start event -> CLEAR; Level loads 1 and Lives loads LIVES.
- CLEAR: StartCount=1 and GameActive=1 for exactly one cycle, then -> PLAY.
- PLAY: GameActive=1, StartCount=0.
  - Home event -> CountSignal_OutLow low for the next cycle.
  - Death event -> Lives decrements. If Lives was 1: Lives becomes 0 and the next state is LOSE.
  - Progress_InBus >= GOAL (unsigned compare) and Level==MAXLEVEL -> WIN.
  - Progress_InBus >= GOAL and Level<MAXLEVEL -> LEVELUP.
- Priority in PLAY when events coincide in the same cycle: LOSE > WIN/LEVELUP > stay.
  - A home event coincident with a death event still emits its count pulse.
- LEVELUP: one cycle.
  - Level increments; LevelUp_Out=1; StartCount=1; GameActive=1.
  - Home and death events in this cycle are ignored.
  - Then -> PLAY.
- WIN and LOSE:
  - GameActive=0; Win_Out or Lose_Out high respectively; Level and Lives hold.
  - Home and death events are ignored.
  - Start event -> CLEAR, reloading Level=1 and Lives=LIVES.
- A start event in PLAY, CLEAR or LEVELUP is ignored.
- Level never exceeds MAXLEVEL.
- Lives never wraps below 0.

## Timing
- Reset values (asserted asynchronously, released on a clock edge):
  - state=IDLE, Level=0, Lives=0, CountSignal_OutLow=1, StartCount=0, GameActive=0, LevelUp=0, Win=0, Lose=0.
  - All edge-detect registers reset to their inactive level (StartButton previous=1, others=0).
- Input-to-output latency:
  - FrogHome rises before edge n -> CountSignal_OutLow low during cycle n+1 only.
  - The counter updates at n+2.
  - The sequencer sees goal at n+2 and enters LEVELUP or WIN at edge n+3.
- A FrogHome held high produces exactly one pulse.
- Back-to-back home events in consecutive cycles produce consecutive pulses.
- Start event to CLEAR: 1 cycle. CLEAR to PLAY: 1 cycle.
- Death to Lives update: 1 cycle.
- Reset asserted mid-game returns to IDLE immediately and drops any in-flight count pulse (CountSignal_OutLow forced to 1).

## Configuration
- Macro: SC_LEVELSEQUENCER_LIVES_EN.
- Defined: lives counter, FrogDead edge detection and the LOSE state are present as described.
- Undefined:
  - FrogDead_In is ignored.
  - Lives_OutBus and Lose_Out are tied to 0.
  - LOSE is unreachable; the game ends only in WIN.

## Test plan
- Reset, then start low for 1 cycle -> CLEAR one cycle with StartCount=1, then PLAY with Level=1, Lives=3, GameActive=1.
- In PLAY, FrogHome held high 10 cycles -> exactly one CountSignal_OutLow low cycle, one cycle after the edge.
- Feed Progress_InBus=5 at Level=1 -> one LEVELUP cycle with LevelUp_Out=1 and StartCount=1; Level=2; back in PLAY.
- At Level=4, Progress_InBus=5 -> WIN, Win_Out=1, GameActive=0. Start event -> CLEAR, Level=1, Lives=3.
- Three FrogDead edges (LIVES_EN defined) -> Lives 3,2,1,0; LOSE with Lose_Out=1. Same-cycle goal and last death -> LOSE.
- Reset low during a CountSignal_OutLow pulse -> output immediately 1, all outputs at reset values; a new start event is required to play.
